// File: rtl/exe_stage_mc.sv
// MIPS execute stage: single-cycle ALU with two-level operand forwarding, plus an
// iterative unsigned multiply/divide unit that owns HI/LO and stalls upstream while running.
module exe_stage_mc #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic [REGW-1:0] in_rs_a,
    input  logic [REGW-1:0] in_rs_b,
    input  logic [XLEN-1:0] in_opnd_a,
    input  logic [XLEN-1:0] in_opnd_b,
    input  logic [SHW-1:0]  in_shamt,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_regwrite,
    input  logic            in_memread,
    input  logic            in_memwrite,
    input  logic [REGW-1:0] in_store_reg,
    input  logic [XLEN-1:0] in_store_data,
    input  logic            stall_in,
    input  logic [REGW-1:0] byp_reg,
    input  logic [XLEN-1:0] byp_data,
    input  logic            byp_valid,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic [REGW-1:0] out_rd,
    output logic            out_regwrite,
    output logic            out_memread,
    output logic            out_memwrite,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] fwd_data,
    output logic            fwd_valid,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out,
    output logic            busy
);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MULTU, OP_DIVU, OP_LUI
    } op_t;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t          state, state_next;
    op_t             op;
    logic            accept, is_md, own_ok, last;
    logic [SHW-1:0]  count;
    logic [XLEN-1:0] opnd_a, opnd_b, store_fwd, alu;
    logic [XLEN-1:0] hi, lo, work_hi, work_lo, opnd_m;
    logic [XLEN:0]   mul_sum, div_shift;
    logic            div_take;
    logic [XLEN-1:0] div_rem;

    // Own output register wins over the MEM bypass; specifier 0 always reads the register file.
    function automatic logic [XLEN-1:0] pick(
        input logic [REGW-1:0] spec,    input logic [XLEN-1:0] rf_val,
        input logic            own,     input logic [REGW-1:0] own_rd,
        input logic [XLEN-1:0] own_val, input logic            bv,
        input logic [REGW-1:0] br,      input logic [XLEN-1:0] bd);
        if (spec == '0)                 return rf_val;
        else if (own && own_rd == spec) return own_val;
        else if (bv && br == spec)      return bd;
        return rf_val;
    endfunction

    assign op        = op_t'(in_op);
    assign is_md     = (op == OP_MULTU) || (op == OP_DIVU);
    assign in_ready  = (state == IDLE) && !stall_in;
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign last      = (count == SHW'(XLEN - 1));
    assign own_ok    = out_valid && out_regwrite && !out_memread && !out_memwrite;
    assign opnd_a    = pick(in_rs_a, in_opnd_a, own_ok, out_rd, out_result, byp_valid, byp_reg, byp_data);
    assign opnd_b    = pick(in_rs_b, in_opnd_b, own_ok, out_rd, out_result, byp_valid, byp_reg, byp_data);
    assign store_fwd = pick(in_store_reg, in_store_data, own_ok, out_rd, out_result, byp_valid, byp_reg, byp_data);
    assign fwd_data  = alu;
    assign fwd_valid = in_valid && in_regwrite && !in_memread && !in_memwrite && !is_md;
    assign hi_out    = hi;
    assign lo_out    = lo;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        alu = '0;
        case (op)
            OP_ADD:  alu = opnd_a + opnd_b;
            OP_SUB:  alu = opnd_a - opnd_b;
            OP_AND:  alu = opnd_a & opnd_b;
            OP_OR:   alu = opnd_a | opnd_b;
            OP_XOR:  alu = opnd_a ^ opnd_b;
            OP_NOR:  alu = ~(opnd_a | opnd_b);
            OP_SLT:  alu = XLEN'($signed(opnd_a) < $signed(opnd_b));
            OP_SLTU: alu = XLEN'(opnd_a < opnd_b);
            OP_SLL:  alu = opnd_b << in_shamt;
            OP_SRL:  alu = opnd_b >> in_shamt;
            OP_SRA:  alu = $unsigned($signed(opnd_b) >>> in_shamt);
            OP_MFHI: alu = hi;
            OP_MFLO: alu = lo;
            OP_LUI:  alu = opnd_b << (XLEN / 2);
            default: alu = '0;
        endcase
    end

    // One radix-2 step of each iterative algorithm; work_hi is the partial product / remainder.
    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd_m} : '0);
    assign div_shift = {work_hi, work_lo[XLEN-1]};
    assign div_take  = div_shift >= {1'b0, opnd_m};
    assign div_rem   = div_take ? div_shift[XLEN-1:0] - opnd_m : div_shift[XLEN-1:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && op == OP_MULTU)     state_next = MUL;
                else if (accept && op == OP_DIVU) state_next = DIV;
            end
            MUL, DIV: if (last) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count   <= '0;
            work_hi <= '0;
            work_lo <= '0;
            opnd_m  <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: if (accept && is_md) begin
                    count   <= '0;
                    work_hi <= '0;
                    work_lo <= opnd_a;
                    opnd_m  <= opnd_b;
                end
                MUL: begin
                    count   <= count + SHW'(1);
                    work_hi <= mul_sum[XLEN:1];
                    work_lo <= {mul_sum[0], work_lo[XLEN-1:1]};
                    if (last) begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], work_lo[XLEN-1:1]};
                    end
                end
                DIV: begin
                    count   <= count + SHW'(1);
                    work_hi <= div_rem;
                    work_lo <= {work_lo[XLEN-2:0], div_take};
                    if (last) begin
                        hi <= div_rem;
                        lo <= {work_lo[XLEN-2:0], div_take};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_rd         <= '0;
            out_regwrite   <= 1'b0;
            out_memread    <= 1'b0;
            out_memwrite   <= 1'b0;
            out_store_data <= '0;
        end else if (!stall_in) begin
            if (accept && !is_md) begin
                out_valid      <= 1'b1;
                out_result     <= alu;
                out_rd         <= in_rd;
                out_regwrite   <= in_regwrite;
                out_memread    <= in_memread;
                out_memwrite   <= in_memwrite;
                out_store_data <= store_fwd;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Bench for exe_stage_mc: vector table through a scoreboard, multi-cycle and stall sequences
// on a 32-bit instance, and a few datapath corner cases on a 16-bit instance.
module tb_exe_stage_mc;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int SHW  = 5;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,   OP_OR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_NOR = 4'd5,  OP_SLT = 4'd6,   OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8,  OP_SRL = 4'd9,  OP_SRA = 4'd10,  OP_MFHI = 4'd11;
    localparam logic [3:0] OP_MFLO = 4'd12, OP_MULTU = 4'd13, OP_DIVU = 4'd14, OP_LUI = 4'd15;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic            in_valid, in_ready, in_regwrite, in_memread, in_memwrite;
    logic [3:0]      in_op;
    logic [REGW-1:0] in_rs_a, in_rs_b, in_rd, in_store_reg, byp_reg, out_rd;
    logic [XLEN-1:0] in_opnd_a, in_opnd_b, in_store_data, byp_data;
    logic [SHW-1:0]  in_shamt;
    logic            stall_in, byp_valid, out_valid, out_regwrite, out_memread, out_memwrite;
    logic [XLEN-1:0] out_result, out_store_data, fwd_data, hi_out, lo_out;
    logic            fwd_valid, busy;

    exe_stage_mc #(.XLEN(XLEN), .REGW(REGW)) u_dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_opnd_a(in_opnd_a), .in_opnd_b(in_opnd_b),
        .in_shamt(in_shamt), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .in_memread(in_memread), .in_memwrite(in_memwrite),
        .in_store_reg(in_store_reg), .in_store_data(in_store_data),
        .stall_in(stall_in), .byp_reg(byp_reg), .byp_data(byp_data), .byp_valid(byp_valid),
        .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
        .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
        .out_store_data(out_store_data), .fwd_data(fwd_data), .fwd_valid(fwd_valid),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy)
    );

    // 16-bit instance for narrow-datapath corner cases
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_regwrite, s_out_memread, s_out_memwrite;
    logic [3:0]  s_in_op, s_in_shamt;
    logic [4:0]  s_out_rd;
    logic [15:0] s_in_opnd_a, s_in_opnd_b, s_out_result, s_out_store_data, s_fwd_data, s_hi_out, s_lo_out;
    logic        s_fwd_valid, s_busy;

    exe_stage_mc #(.XLEN(16), .REGW(5)) u_dut16 (
        .CLK(CLK), .RESET(RESET),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op),
        .in_rs_a(5'd0), .in_rs_b(5'd0), .in_opnd_a(s_in_opnd_a), .in_opnd_b(s_in_opnd_b),
        .in_shamt(s_in_shamt), .in_rd(5'd0), .in_regwrite(1'b0),
        .in_memread(1'b0), .in_memwrite(1'b0),
        .in_store_reg(5'd0), .in_store_data(16'd0),
        .stall_in(1'b0), .byp_reg(5'd0), .byp_data(16'd0), .byp_valid(1'b0),
        .out_valid(s_out_valid), .out_result(s_out_result), .out_rd(s_out_rd),
        .out_regwrite(s_out_regwrite), .out_memread(s_out_memread), .out_memwrite(s_out_memwrite),
        .out_store_data(s_out_store_data), .fwd_data(s_fwd_data), .fwd_valid(s_fwd_valid),
        .hi_out(s_hi_out), .lo_out(s_lo_out), .busy(s_busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs_a, rs_b, rd, st_reg, br, shamt;
        logic [31:0] a, b, st_data, bd, exp_result, exp_store;
        logic        rw, mr, mw, bv;
    } vec_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rw, mr, mw;
        logic [31:0] store;
    } exp_t;

    exp_t sb[$];
    exp_t mon_act, mon_exp;
    vec_t vecs[18];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [4:0] rs_a, input logic [31:0] a,
                                input logic [4:0] rs_b, input logic [31:0] b, input logic [4:0] shamt,
                                input logic [4:0] rd, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.rs_a = rs_a; v.a = a; v.rs_b = rs_b; v.b = b; v.shamt = shamt; v.rd = rd;
        v.rw = 1'b1; v.mr = 1'b0; v.mw = 1'b0;
        v.st_reg = '0; v.st_data = '0; v.bv = 1'b0; v.br = '0; v.bd = '0;
        v.exp_result = exp; v.exp_store = '0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_valid = 1'b1; in_op = v.op; in_rs_a = v.rs_a; in_rs_b = v.rs_b;
        in_opnd_a = v.a; in_opnd_b = v.b; in_shamt = v.shamt; in_rd = v.rd;
        in_regwrite = v.rw; in_memread = v.mr; in_memwrite = v.mw;
        in_store_reg = v.st_reg; in_store_data = v.st_data;
        byp_valid = v.bv; byp_reg = v.br; byp_data = v.bd;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_rs_a = '0; in_rs_b = '0; in_store_reg = '0; byp_valid = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted v.
    task automatic issue(input vec_t v);
        int guard = 0;
        drive(v);
        @(negedge CLK);
        while (!in_ready && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (!in_ready) begin
            check("issue_timeout", 64'd1, 64'd0);
        end else if (v.op != OP_MULTU && v.op != OP_DIVU) begin
            sb.push_back({v.exp_result, v.rd, v.rw, v.mr, v.mw, v.exp_store});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic mdu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        vec_t v;
        int lat, busy_cnt;
        v = mk(op, 5'd0, a, 5'd0, b, 5'd0, 5'd0, 32'd0);
        v.rw = 1'b0;
        issue(v);
        idle();
        lat = 1;
        busy_cnt = 0;
        @(negedge CLK);
        while (!in_ready && lat < 100) begin
            if (busy) busy_cnt++;
            lat++;
            @(negedge CLK);
        end
        check({tag, "_latency"}, 64'(lat), 64'(XLEN + 1));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(XLEN));
        @(posedge CLK);
        #1;
    endtask

    task automatic mul16(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_hi, input logic [15:0] exp_lo);
        int g = 0;
        s_in_valid = 1'b1; s_in_op = OP_MULTU; s_in_opnd_a = a; s_in_opnd_b = b;
        @(posedge CLK);
        #1;
        s_in_valid = 1'b0;
        check("x16_multu_busy", 64'(s_busy), 64'd1);
        while (s_busy && g < 100) begin
            @(posedge CLK);
            #1;
            g++;
        end
        check("x16_multu_hi", 64'(s_hi_out), 64'(exp_hi));
        check("x16_multu_lo", 64'(s_lo_out), 64'(exp_lo));
    endtask

    // Scoreboard monitor: a fresh output appears on any unstalled edge with out_valid set.
    logic stalled_q = 1'b0;
    always @(posedge CLK) stalled_q <= stall_in;

    always @(negedge CLK) begin
        if (!RESET && out_valid && !stalled_q) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out_valid: got result=%h rd=%0d, expected no output", out_result, out_rd);
            end else begin
                mon_exp = sb.pop_front();
                mon_act = {out_result, out_rd, out_regwrite, out_memread, out_memwrite, out_store_data};
                if (mon_act !== mon_exp) begin
                    n_bad++;
                    $display("FAIL out_vec: got result=%h rd=%0d ctl=%b%b%b store=%h, expected result=%h rd=%0d ctl=%b%b%b store=%h",
                             mon_act.result, mon_act.rd, mon_act.rw, mon_act.mr, mon_act.mw, mon_act.store,
                             mon_exp.result, mon_exp.rd, mon_exp.rw, mon_exp.mr, mon_exp.mw, mon_exp.store);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v, v2;

        vecs[0]  = mk(OP_ADD,  5'd0,  32'd5,         5'd0, 32'd7,         5'd0,  5'd3,  32'd12);
        vecs[1]  = mk(OP_SUB,  5'd3,  32'd0,         5'd0, 32'd2,         5'd0,  5'd4,  32'd10);
        vecs[2]  = mk(OP_SUB,  5'd3,  32'd0,         5'd0, 32'd2,         5'd0,  5'd5,  32'd97);
        vecs[2].bv = 1'b1; vecs[2].br = 5'd3; vecs[2].bd = 32'd99;
        vecs[3]  = mk(OP_AND,  5'd0,  32'hF0F0_1234, 5'd0, 32'h0FF0_FFFF, 5'd0,  5'd6,  32'h00F0_1234);
        vecs[4]  = mk(OP_OR,   5'd0,  32'h0000_0001, 5'd6, 32'd0,         5'd0,  5'd7,  32'h00F0_1235);
        vecs[4].bv = 1'b1; vecs[4].br = 5'd6; vecs[4].bd = 32'h5555;
        vecs[5]  = mk(OP_XOR,  5'd0,  32'hFFFF_0000, 5'd0, 32'h0F0F_0F0F, 5'd0,  5'd8,  32'hF0F0_0F0F);
        vecs[6]  = mk(OP_NOR,  5'd0,  32'hF000_0000, 5'd0, 32'h0000_000F, 5'd0,  5'd9,  32'h0FFF_FFF0);
        vecs[7]  = mk(OP_SLT,  5'd0,  32'hFFFF_FFFF, 5'd0, 32'd1,         5'd0,  5'd10, 32'd1);
        vecs[8]  = mk(OP_SLTU, 5'd0,  32'hFFFF_FFFF, 5'd0, 32'd1,         5'd0,  5'd11, 32'd0);
        vecs[9]  = mk(OP_SLL,  5'd0,  32'd3,         5'd0, 32'd3,         5'd4,  5'd12, 32'h30);
        vecs[10] = mk(OP_SRL,  5'd0,  32'h8000_0000, 5'd0, 32'h8000_0000, 5'd31, 5'd13, 32'd1);
        vecs[11] = mk(OP_SRA,  5'd0,  32'h8000_0000, 5'd0, 32'h8000_0000, 5'd4,  5'd14, 32'hF800_0000);
        vecs[12] = mk(OP_LUI,  5'd0,  32'd0,         5'd0, 32'h0000_1234, 5'd0,  5'd15, 32'h1234_0000);
        vecs[13] = mk(OP_ADD,  5'd0,  32'hFFFF_FFFF, 5'd0, 32'd3,         5'd0,  5'd16, 32'd2);
        vecs[14] = mk(OP_ADD,  5'd0,  32'd100,       5'd0, 32'd8,         5'd0,  5'd0,  32'd108);
        vecs[14].rw = 1'b0; vecs[14].mw = 1'b1; vecs[14].st_reg = 5'd16; vecs[14].st_data = 32'd777;
        vecs[14].exp_store = 32'd2;
        vecs[15] = mk(OP_ADD,  5'd0,  32'd200,       5'd0, 32'd4,         5'd0,  5'd18, 32'd204);
        vecs[15].mr = 1'b1; vecs[15].st_reg = 5'd21; vecs[15].st_data = 32'd1;
        vecs[15].bv = 1'b1; vecs[15].br = 5'd21; vecs[15].bd = 32'hBEEF; vecs[15].exp_store = 32'hBEEF;
        vecs[16] = mk(OP_ADD,  5'd18, 32'd1,         5'd0, 32'd1,         5'd0,  5'd19, 32'd2);
        vecs[17] = mk(OP_ADD,  5'd0,  32'd3,         5'd0, 32'd4,         5'd0,  5'd20, 32'd7);
        vecs[17].bv = 1'b1; vecs[17].br = 5'd0; vecs[17].bd = 32'd50;

        RESET = 1'b1; stall_in = 1'b0;
        in_op = '0; in_opnd_a = '0; in_opnd_b = '0; in_shamt = '0; in_rd = '0;
        in_regwrite = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0;
        in_store_data = '0; byp_reg = '0; byp_data = '0;
        idle();
        s_in_valid = 1'b0; s_in_op = '0; s_in_opnd_a = '0; s_in_opnd_b = '0; s_in_shamt = '0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;

        @(negedge CLK);
        check("reset_out_valid",  64'(out_valid),  64'd0);
        check("reset_out_result", 64'(out_result), 64'd0);
        check("reset_hi",         64'(hi_out),     64'd0);
        check("reset_lo",         64'(lo_out),     64'd0);
        check("reset_busy",       64'(busy),       64'd0);
        check("reset_in_ready",   64'(in_ready),   64'd1);
        @(posedge CLK);
        #1;

        for (int i = 0; i < 18; i++) issue(vecs[i]);
        idle();
        repeat (2) @(posedge CLK);
        #1;

        mdu(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
        check("multu_hi_out", 64'(hi_out), 64'hFFFF_FFFE);
        check("multu_lo_out", 64'(lo_out), 64'h0000_0001);
        issue(mk(OP_MFHI, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd1, 32'hFFFF_FFFE));
        issue(mk(OP_MFLO, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd2, 32'h0000_0001));
        idle();

        mdu(OP_DIVU, 32'd100, 32'd7, "divu");
        issue(mk(OP_MFLO, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd1, 32'd14));
        issue(mk(OP_MFHI, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd2, 32'd2));
        idle();

        mdu(OP_DIVU, 32'd5, 32'd0, "divu_zero");
        issue(mk(OP_MFLO, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd1, 32'hFFFF_FFFF));
        issue(mk(OP_MFHI, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd2, 32'd5));
        idle();

        v  = mk(OP_AND, 5'd0, 32'hFF00_FF00, 5'd0, 32'h0F0F_0F0F, 5'd0, 5'd22, 32'h0F00_0F00);
        v2 = mk(OP_OR,  5'd0, 32'd1,         5'd0, 32'd2,         5'd0, 5'd23, 32'd3);
        issue(v);
        stall_in = 1'b1;
        drive(v2);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("stall_in_ready",   64'(in_ready),   64'd0);
            check("stall_out_valid",  64'(out_valid),  64'd1);
            check("stall_out_result", 64'(out_result), 64'h0F00_0F00);
            @(posedge CLK);
            #1;
        end
        stall_in = 1'b0;
        issue(v2);
        idle();
        repeat (2) @(posedge CLK);
        #1;

        s_in_op = OP_SRA; s_in_opnd_a = 16'h8000; s_in_opnd_b = 16'h8000; s_in_shamt = 4'd15;
        #1 check("x16_sra", 64'(s_fwd_data), 64'hFFFF);
        s_in_op = OP_SLT; s_in_opnd_a = 16'hFFFF; s_in_opnd_b = 16'h0001; s_in_shamt = 4'd0;
        #1 check("x16_slt", 64'(s_fwd_data), 64'd1);
        s_in_op = OP_SLTU;
        #1 check("x16_sltu", 64'(s_fwd_data), 64'd0);
        @(posedge CLK);
        #1;
        mul16(16'h00FF, 16'h0101, 16'h0000, 16'hFFFF);   // 255 * 257 = 65535
        mul16(16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);

        issue(mk(OP_DIVU, 5'd0, 32'd1000, 5'd0, 32'd3, 5'd0, 5'd0, 32'd0));
        idle();
        repeat (9) @(posedge CLK);
        #1;
        check("pre_reset_busy", 64'(busy), 64'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("abort_busy",      64'(busy),      64'd0);
        check("abort_hi",        64'(hi_out),    64'd0);
        check("abort_lo",        64'(lo_out),    64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready",  64'(in_ready),  64'd1);

        repeat (2) @(posedge CLK);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
